// File: rtl/pwm_cfg_sequencer.sv
// AXI4-Lite write master that arbitrates register-write requests from several
// local requesters onto the PWM IP's four-register slave port, with optional read-back.
module pwm_cfg_sequencer #(
    parameter int NUM_REQ          = 2,
    parameter int C_AXI_ADDR_WIDTH = 4,
    parameter int BASE_ADDR        = 0,
    parameter int VERIFY           = 1,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [2*NUM_REQ-1:0]          req_reg,
    input  logic [32*NUM_REQ-1:0]         req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            done,
    output logic                          done_err,
    output logic                          busy,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WR     = 3'd1;
    localparam logic [2:0] ST_WAIT_B = 3'd2;
    localparam logic [2:0] ST_RD_A   = 3'd3;
    localparam logic [2:0] ST_WAIT_R = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    logic [2:0]                  state_reg, state_next;
    logic [GW-1:0]               grant_reg;
    logic [GW-1:0]               ptr_reg;
    logic [31:0]                 data_reg;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_reg;
    logic                        awvalid_reg;
    logic                        wvalid_reg;
    logic                        err_reg;
    logic [7:0]                  tmo_cnt_reg;

    logic [1:0]    req_reg_arr  [NUM_REQ];
    logic [31:0]   req_data_arr [NUM_REQ];
    logic [GW-1:0] arb_idx;
    logic          arb_found;
    logic          grant_fire;
    logic          wr_complete;
    logic          tmo_hit;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_reg_arr[gi]  = req_reg[2*gi +: 2];
            assign req_data_arr[gi] = req_data[32*gi +: 32];
            // Accept pulse is masked during reset so every output reads 0 while ARESETN is low.
            assign req_ready[gi] = grant_fire && ARESETN && (arb_idx == GW'(gi));
            assign done[gi]      = (state_reg == ST_DONE) && (grant_reg == GW'(gi));
        end
    endgenerate

    // Round-robin: scanning offsets high to low lets the lowest offset from the pointer win.
    always_comb begin
        int idx;
        idx       = 0;
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_reg) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                arb_idx   = GW'(idx);
                arb_found = 1'b1;
            end
        end
    end

    assign grant_fire  = (state_reg == ST_IDLE) && arb_found;
    assign wr_complete = (!awvalid_reg || M_AXI_AWREADY) && (!wvalid_reg || M_AXI_WREADY);
    assign tmo_hit     = (tmo_cnt_reg == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (arb_found) state_next = ST_WR;
            ST_WR:     if (wr_complete) state_next = ST_WAIT_B;
            ST_WAIT_B: begin
                if (M_AXI_BVALID)
                    state_next = ((M_AXI_BRESP != 2'b00) || (VERIFY == 0)) ? ST_DONE : ST_RD_A;
                else if (tmo_hit)
                    state_next = ST_DONE;
            end
            ST_RD_A:   if (M_AXI_ARREADY) state_next = ST_WAIT_R;
            ST_WAIT_R: if (M_AXI_RVALID || tmo_hit) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            ptr_reg     <= '0;
            data_reg    <= '0;
            addr_reg    <= '0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            err_reg     <= 1'b0;
            tmo_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (arb_found) begin
                        grant_reg   <= arb_idx;
                        data_reg    <= req_data_arr[arb_idx];
                        addr_reg    <= C_AXI_ADDR_WIDTH'(BASE_ADDR)
                                     + C_AXI_ADDR_WIDTH'({req_reg_arr[arb_idx], 2'b00});
                        awvalid_reg <= 1'b1;
                        wvalid_reg  <= 1'b1;
                        err_reg     <= 1'b0;
                    end
                end
                ST_WR: begin
                    if (awvalid_reg && M_AXI_AWREADY) awvalid_reg <= 1'b0;
                    if (wvalid_reg && M_AXI_WREADY)   wvalid_reg  <= 1'b0;
                    tmo_cnt_reg <= '0;
                end
                ST_WAIT_B: begin
                    tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    if (M_AXI_BVALID)  err_reg <= (M_AXI_BRESP != 2'b00);
                    else if (tmo_hit)  err_reg <= 1'b1;
                end
                ST_RD_A: tmo_cnt_reg <= '0;
                ST_WAIT_R: begin
                    tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    if (M_AXI_RVALID)
                        err_reg <= (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != data_reg);
                    else if (tmo_hit)
                        err_reg <= 1'b1;
                end
                ST_DONE: begin
                    ptr_reg <= (grant_reg == GW'(NUM_REQ - 1)) ? '0 : grant_reg + GW'(1);
                    err_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign done_err      = (state_reg == ST_DONE) && err_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign M_AXI_AWADDR  = addr_reg;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_reg;
    assign M_AXI_WDATA   = data_reg;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_reg;
    assign M_AXI_BREADY  = (state_reg == ST_WAIT_B);
    assign M_AXI_ARADDR  = addr_reg;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state_reg == ST_RD_A);
    assign M_AXI_RREADY  = (state_reg == ST_WAIT_R);

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer: a small AXI4-Lite slave model with
// configurable delays/errors, and a monitor logging grants, completions and handshakes.
module tb_pwm_cfg_sequencer;

    localparam int NR = 2;
    localparam int AW = 4;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic [NR-1:0]     req_valid;
    logic [2*NR-1:0]   req_reg;
    logic [32*NR-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     done;
    logic              done_err;
    logic              busy;
    logic [AW-1:0]     M_AXI_AWADDR;
    logic [2:0]        M_AXI_AWPROT;
    logic              M_AXI_AWVALID;
    logic              M_AXI_AWREADY;
    logic [31:0]       M_AXI_WDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_WVALID;
    logic              M_AXI_WREADY;
    logic [1:0]        M_AXI_BRESP;
    logic              M_AXI_BVALID;
    logic              M_AXI_BREADY;
    logic [AW-1:0]     M_AXI_ARADDR;
    logic [2:0]        M_AXI_ARPROT;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [31:0]       M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    pwm_cfg_sequencer #(
        .NUM_REQ(NR), .C_AXI_ADDR_WIDTH(AW), .BASE_ADDR(0), .VERIFY(1), .TIMEOUT_CYCLES(255)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
        .req_ready(req_ready), .done(done), .done_err(done_err), .busy(busy),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    // Slave configuration, set by the stimulus process between transactions.
    int          aw_delay = 0;
    int          w_delay  = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    bit          b_hang = 1'b0;
    bit          rd_ovr = 1'b0;
    logic [31:0] rd_ovr_val = 32'h0;

    // Slave state and monitor counters, written only by the slave/monitor process.
    logic [31:0] mem [4];
    int          aw_wait, w_wait;
    bit          aw_got, w_got, b_pending, r_pending, bready_prev;
    logic [AW-1:0] wr_addr, rd_addr, last_awaddr, last_araddr;
    logic [31:0] wr_data, last_wdata;
    int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0;
    int          awv_cyc = 0, wv_cyc = 0, bready_cyc = 0, bready_rise = 0;
    int          done_n = 0, done_err_n = 0;
    int          ev_log [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Slave outputs change just after the rising edge; handshakes are observed at the falling edge.
    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        aw_wait = 0; w_wait = 0; aw_got = 0; w_got = 0; b_pending = 0; r_pending = 0;
        bready_prev = 0; wr_addr = 0; rd_addr = 0; wr_data = 0;
        last_awaddr = 0; last_araddr = 0; last_wdata = 0;
        forever begin
            @(posedge ACLK); #1;
            if (!ARESETN) begin
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
                aw_wait = 0; w_wait = 0;
            end else begin
                if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_wait >= aw_delay); aw_wait++; end
                else begin M_AXI_AWREADY = 0; aw_wait = 0; end
                if (M_AXI_WVALID) begin M_AXI_WREADY = (w_wait >= w_delay); w_wait++; end
                else begin M_AXI_WREADY = 0; w_wait = 0; end
                M_AXI_BVALID  = b_pending;
                M_AXI_BRESP   = bresp_cfg;
                M_AXI_ARREADY = M_AXI_ARVALID;
                M_AXI_RVALID  = r_pending;
                M_AXI_RDATA   = rd_ovr ? rd_ovr_val : mem[rd_addr[3:2]];
                M_AXI_RRESP   = 2'b00;
            end
            @(negedge ACLK);
            if (!ARESETN) begin
                aw_got = 0; w_got = 0; b_pending = 0; r_pending = 0; bready_prev = 0;
            end else begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                    aw_got = 1; wr_addr = M_AXI_AWADDR; last_awaddr = M_AXI_AWADDR; aw_hs_n++;
                end
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    w_got = 1; wr_data = M_AXI_WDATA; last_wdata = M_AXI_WDATA; w_hs_n++;
                end
                if (M_AXI_BVALID && M_AXI_BREADY) b_pending = 0;
                if (aw_got && w_got) begin
                    mem[wr_addr[3:2]] = wr_data;
                    if (!b_hang) b_pending = 1;
                    aw_got = 0; w_got = 0;
                end
                if (M_AXI_RVALID && M_AXI_RREADY) r_pending = 0;
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    r_pending = 1; rd_addr = M_AXI_ARADDR; last_araddr = M_AXI_ARADDR; ar_hs_n++;
                end
                if (M_AXI_AWVALID) awv_cyc++;
                if (M_AXI_WVALID)  wv_cyc++;
                if (M_AXI_BREADY)  bready_cyc++;
                if (M_AXI_BREADY && !bready_prev) bready_rise++;
                bready_prev = M_AXI_BREADY;
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i]) ev_log.push_back(i);
                    if (done[i]) begin ev_log.push_back(10 + i); done_n++; end
                end
                if ((done != '0) && done_err) done_err_n++;
            end
        end
    end

    // One request: raise req_valid, wait for the accept pulse, then count cycles to done.
    task automatic do_req(input string tag, input int idx, input logic [1:0] r,
                          input logic [31:0] d, output int lat, output logic err);
        bit seen;
        lat = -1; err = 1'bx;
        @(posedge ACLK); #1;
        req_valid[idx] = 1'b1;
        req_reg[2*idx +: 2] = r;
        req_data[32*idx +: 32] = d;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge ACLK);
            if (req_ready[idx]) seen = 1;
        end
        check_val({tag, "_accept"}, 32'(seen), 32'd1);
        @(posedge ACLK); #1;
        req_valid[idx] = 1'b0;
        seen = 0;
        for (int k = 1; k <= 400 && !seen; k++) begin
            @(negedge ACLK);
            if (done[idx]) begin seen = 1; lat = k; err = done_err; end
        end
        check_val({tag, "_done"}, 32'(seen), 32'd1);
        $display("txn %s: req%0d reg%0d data=0x%08h lat=%0d err=%0b", tag, idx, r, d, lat, err);
    endtask

    initial begin
        int          lat;
        logic        err;
        int          snap_a, snap_b, snap_c;
        int          exp_log [8];
        bit          seen;

        exp_log = '{0, 10, 1, 11, 0, 10, 1, 11};
        req_valid = '0; req_reg = '0; req_data = '0;
        ARESETN = 1'b0;
        #12;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
        check_val("rst_done", 32'({done, done_err, req_ready}), 32'd0);
        check_val("rst_addr", 32'({M_AXI_AWADDR, M_AXI_ARADDR}), 32'd0);
        @(posedge ACLK); #1 ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);

        // Basic write + verify from requester 0
        do_req("basic", 0, 2'd1, 32'h0000_00C8, lat, err);
        check_val("basic_awaddr", 32'(last_awaddr), 32'h4);
        check_val("basic_wdata", last_wdata, 32'hC8);
        check_val("basic_ar_cnt", 32'(ar_hs_n), 32'd1);
        check_val("basic_araddr", 32'(last_araddr), 32'h4);
        check_val("basic_err", 32'(err), 32'd0);
        check_val("basic_latency", 32'(lat), 32'd5);

        // Round robin with both requesters always pending
        @(posedge ACLK); #1 ARESETN = 1'b0;
        @(posedge ACLK); #1 ARESETN = 1'b1;
        ev_log.delete();
        snap_a = done_n; snap_b = done_err_n;
        req_reg = {2'd2, 2'd0};
        req_data = {32'h22, 32'h11};
        req_valid = 2'b11;
        for (int k = 0; k < 200 && (done_n - snap_a) < 4; k++) begin
            @(posedge ACLK); #1;
        end
        req_valid = 2'b00;
        repeat (10) @(posedge ACLK);
        #1;
        check_val("rr_log_len", 32'(ev_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check_val($sformatf("rr_event%0d", i), (i < ev_log.size()) ? 32'(ev_log[i]) : 32'hFFFF_FFFF,
                      32'(exp_log[i]));
        check_val("rr_mem0", mem[0], 32'h11);
        check_val("rr_mem2", mem[2], 32'h22);
        check_val("rr_err_cnt", 32'(done_err_n - snap_b), 32'd0);
        $display("txn rr: %0d events logged", ev_log.size());

        // AWREADY late, WREADY immediate
        aw_delay = 3;
        snap_a = awv_cyc; snap_b = wv_cyc; snap_c = bready_rise;
        do_req("awdly", 1, 2'd2, 32'h77, lat, err);
        aw_delay = 0;
        check_val("awdly_wvalid_cyc", 32'(wv_cyc - snap_b), 32'd1);
        check_val("awdly_awvalid_cyc", 32'(awv_cyc - snap_a), 32'd4);
        check_val("awdly_waitb_entries", 32'(bready_rise - snap_c), 32'd1);
        check_val("awdly_awaddr", 32'(last_awaddr), 32'h8);
        check_val("awdly_err", 32'(err), 32'd0);

        // Write error response skips the read-back
        bresp_cfg = 2'b10;
        snap_a = ar_hs_n;
        do_req("bresp", 0, 2'd3, 32'h5, lat, err);
        bresp_cfg = 2'b00;
        check_val("bresp_no_read", 32'(ar_hs_n - snap_a), 32'd0);
        check_val("bresp_awaddr", 32'(last_awaddr), 32'hC);
        check_val("bresp_err", 32'(err), 32'd1);

        // Read-back mismatch, then a clean transaction
        rd_ovr = 1'b1; rd_ovr_val = 32'hDEAD;
        do_req("mismatch", 1, 2'd0, 32'h1234, lat, err);
        rd_ovr = 1'b0;
        check_val("mismatch_err", 32'(err), 32'd1);
        do_req("after_mm", 0, 2'd1, 32'h99, lat, err);
        check_val("after_mm_err", 32'(err), 32'd0);
        check_val("after_mm_araddr", 32'(last_araddr), 32'h4);
        check_val("after_mm_latency", 32'(lat), 32'd5);

        // Write response never arrives
        b_hang = 1'b1;
        snap_a = bready_cyc; snap_b = ar_hs_n;
        do_req("timeout", 0, 2'd2, 32'hAB, lat, err);
        b_hang = 1'b0;
        check_val("timeout_bready_cyc", 32'(bready_cyc - snap_a), 32'd255);
        check_val("timeout_err", 32'(err), 32'd1);
        check_val("timeout_no_read", 32'(ar_hs_n - snap_b), 32'd0);

        // Reset in the middle of a write; pointer is 1 at this point
        @(posedge ACLK); #1;
        req_valid[0] = 1'b1; req_reg[1:0] = 2'd3; req_data[31:0] = 32'h3C;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge ACLK);
            if (req_ready[0]) seen = 1;
        end
        check_val("midrst_accept", 32'(seen), 32'd1);
        @(posedge ACLK); #1 req_valid = '0;
        @(negedge ACLK);
        check_val("midrst_in_wr", 32'(M_AXI_AWVALID), 32'd1);
        #2 ARESETN = 1'b0;
        #1;
        check_val("midrst_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
        check_val("midrst_status", 32'({done, done_err, busy, req_ready}), 32'd0);
        check_val("midrst_data", M_AXI_WDATA, 32'd0);
        snap_a = done_n;
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (10) @(posedge ACLK);
        #1;
        check_val("midrst_no_done", 32'(done_n - snap_a), 32'd0);
        ev_log.delete();
        req_reg = {2'd1, 2'd0};
        req_data = {32'hB1, 32'hA0};
        req_valid = 2'b11;
        for (int k = 0; k < 50 && ev_log.size() == 0; k++) begin
            @(posedge ACLK); #1;
        end
        req_valid = 2'b00;
        check_val("midrst_first_grant", (ev_log.size() > 0) ? 32'(ev_log[0]) : 32'hFFFF_FFFF, 32'd0);
        for (int k = 0; k < 50 && done_n == snap_a; k++) begin
            @(posedge ACLK); #1;
        end
        check_val("midrst_next_done", 32'(done_n - snap_a), 32'd1);
        check_val("midrst_next_data", last_wdata, 32'hA0);
        $display("txn midrst: first grant after reset logged, %0d events", ev_log.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
